// File: rtl/kersram_w_if.sv
// Kernel SRAM write stage bus bundle: schedule handshake, input word
// stream and the shared SRAM write pins.
// Optional checksum output is present when KERSW_CKSUM_EN is defined.
interface kersram_w_if #(
    parameter int DATA_BITS     = 64,
    parameter int ADDR_CNT_BITS = 10,
    parameter int BANK_NUM      = 8
);
    // schedule handshake
    logic                     start_ker_write;
    logic                     ker_write_busy;
    logic                     ker_write_done;
    // input word stream
    logic                     din_valid;
    logic                     din_ready;
    logic [DATA_BITS-1:0]     din_data;
    // SRAM write side
    logic [BANK_NUM-1:0]      cen_kersw;
    logic [BANK_NUM-1:0]      wen_kersw;
    logic [ADDR_CNT_BITS-1:0] addr_kersw;
    logic [DATA_BITS-1:0]     data_kersw;
    logic [2:0]               cnt_bank_out;
`ifdef KERSW_CKSUM_EN
    logic [31:0]              ker_wr_cksum;
`endif

    // write-stage side
    modport slave (
`ifdef KERSW_CKSUM_EN
        output ker_wr_cksum,
`endif
        input  start_ker_write,
        input  din_valid,
        input  din_data,
        output ker_write_busy,
        output ker_write_done,
        output din_ready,
        output cen_kersw,
        output wen_kersw,
        output addr_kersw,
        output data_kersw,
        output cnt_bank_out
    );

    // scheduler / producer / SRAM side
    modport master (
`ifdef KERSW_CKSUM_EN
        input  ker_wr_cksum,
`endif
        output start_ker_write,
        output din_valid,
        output din_data,
        input  ker_write_busy,
        input  ker_write_done,
        input  din_ready,
        input  cen_kersw,
        input  wen_kersw,
        input  addr_kersw,
        input  data_kersw,
        input  cnt_bank_out
    );
endinterface

// File: rtl/kersram_w.sv
// Kernel SRAM write stage.
// Accepts a valid/ready stream of kernel words and writes them into the
// 8 kernel SRAM banks in order: bank 0 addresses 0..KER_ST_LENGTH-1, then
// bank 1, ... bank 7. Completion is reported with a busy/done handshake.
// SRAM pins are registered: a word accepted at edge k drives the pins
// during cycle k..k+1 and is written by the SRAM at edge k+1.
// Optional feature: define KERSW_CKSUM_EN to add the ker_wr_cksum output
// (running 32-bit sum of both halves of every accepted word).
module kersram_w #(
    parameter int DATA_BITS     = 64,
    parameter int ADDR_CNT_BITS = 10,
    parameter int KER_ST_LENGTH = 288,
    parameter int BANK_NUM      = 8
) (
    input  logic        clk,
    input  logic        reset,
    kersram_w_if.slave  bus
);

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_RUN  = 2'd1,
        WR_DONE = 2'd2
    } wr_state_e;

    localparam logic [ADDR_CNT_BITS-1:0] WORD_LAST = ADDR_CNT_BITS'(KER_ST_LENGTH - 1);
    localparam logic [2:0]               BANK_LAST = 3'(BANK_NUM - 1);
    localparam logic [BANK_NUM-1:0]      STROBE_OFF = {BANK_NUM{1'b1}};

    // Active-low one-cold strobe selecting the bank being written.
    function automatic logic [BANK_NUM-1:0] bank_strobe_n(input logic [2:0] bank);
        logic [BANK_NUM-1:0] s;
        for (int i = 0; i < BANK_NUM; i++) begin
            s[i] = (3'(i) == bank) ? 1'b0 : 1'b1;
        end
        return s;
    endfunction

`ifdef KERSW_CKSUM_EN
    // Modulo-2^32 accumulation of both 32-bit halves of a word.
    function automatic logic [31:0] cksum_add(input logic [31:0] acc,
                                              input logic [DATA_BITS-1:0] word);
        return acc + word[31:0] + word[63:32];
    endfunction
`endif

    wr_state_e                state_r;
    logic                     busy_r;
    logic                     done_r;
    logic                     ready_r;
    logic [ADDR_CNT_BITS-1:0] cnt_word_r;
    logic [2:0]               cnt_bank_r;
    logic [BANK_NUM-1:0]      cen_r;
    logic [BANK_NUM-1:0]      wen_r;
    logic [ADDR_CNT_BITS-1:0] addr_r;
    logic [DATA_BITS-1:0]     data_r;
    logic                     accept_s;
    logic                     last_word_s;
    logic                     last_all_s;

    // Handshake decode: a word moves when offered and the stage is running.
    always_comb begin
        accept_s    = bus.din_valid & ready_r;
        last_word_s = (cnt_word_r == WORD_LAST);
        last_all_s  = accept_s & last_word_s & (cnt_bank_r == BANK_LAST);
    end

    // Sequencer: state, word/bank counters and the registered status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= WR_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            ready_r    <= 1'b0;
            cnt_word_r <= {ADDR_CNT_BITS{1'b0}};
            cnt_bank_r <= 3'd0;
        end else begin
            case (state_r)
                WR_IDLE: begin
                    if (bus.start_ker_write) begin
                        state_r    <= WR_RUN;
                        busy_r     <= 1'b1;
                        ready_r    <= 1'b1;
                        done_r     <= 1'b0;
                        cnt_word_r <= {ADDR_CNT_BITS{1'b0}};
                        cnt_bank_r <= 3'd0;
                    end else begin
                        state_r <= WR_IDLE;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                WR_RUN: begin
                    if (accept_s) begin
                        if (last_word_s) begin
                            cnt_word_r <= {ADDR_CNT_BITS{1'b0}};
                            cnt_bank_r <= cnt_bank_r + 3'd1;
                        end else begin
                            cnt_word_r <= cnt_word_r + {{(ADDR_CNT_BITS-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        cnt_word_r <= cnt_word_r;
                        cnt_bank_r <= cnt_bank_r;
                    end
                    if (last_all_s) begin
                        state_r <= WR_DONE;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= WR_RUN;
                        busy_r  <= 1'b1;
                        ready_r <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                WR_DONE: begin
                    // Single-cycle completion; start is not sampled here.
                    state_r <= WR_IDLE;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r    <= WR_IDLE;
                    busy_r     <= 1'b0;
                    ready_r    <= 1'b0;
                    done_r     <= 1'b0;
                    cnt_word_r <= {ADDR_CNT_BITS{1'b0}};
                    cnt_bank_r <= 3'd0;
                end
            endcase
        end
    end

    // SRAM pin registers: strobe one bank per accepted word, otherwise idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cen_r  <= STROBE_OFF;
            wen_r  <= STROBE_OFF;
            addr_r <= {ADDR_CNT_BITS{1'b0}};
            data_r <= {DATA_BITS{1'b0}};
        end else if (accept_s) begin
            cen_r  <= bank_strobe_n(cnt_bank_r);
            wen_r  <= bank_strobe_n(cnt_bank_r);
            addr_r <= cnt_word_r;
            data_r <= bus.din_data;
        end else begin
            // Address and data hold so the bus does not toggle in bubbles.
            cen_r  <= STROBE_OFF;
            wen_r  <= STROBE_OFF;
            addr_r <= addr_r;
            data_r <= data_r;
        end
    end

`ifdef KERSW_CKSUM_EN
    logic [31:0] cksum_r;

    // Running checksum: cleared when a load starts, held after completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cksum_r <= 32'd0;
        end else if ((state_r == WR_IDLE) && bus.start_ker_write) begin
            cksum_r <= 32'd0;
        end else if (accept_s) begin
            cksum_r <= cksum_add(cksum_r, bus.din_data);
        end else begin
            cksum_r <= cksum_r;
        end
    end

    assign bus.ker_wr_cksum = cksum_r;
`endif

    assign bus.ker_write_busy = busy_r;
    assign bus.ker_write_done = done_r;
    assign bus.din_ready      = ready_r;
    assign bus.cen_kersw      = cen_r;
    assign bus.wen_kersw      = wen_r;
    assign bus.addr_kersw     = addr_r;
    assign bus.data_kersw     = data_r;
    assign bus.cnt_bank_out   = cnt_bank_r;

endmodule

// File: tb/tb_kersram_w.sv
// Self-checking bench for kersram_w: directed vector table for the first
// cycles after reset, then full-load, bubble, bank-boundary, start/reset
// interaction and (with KERSW_CKSUM_EN) checksum sequences. An SRAM model
// captures every strobed write for end-of-load content checks.
module tb_kersram_w;
    localparam int DB = 64;
    localparam int AB = 10;
    localparam int KL = 288;
    localparam int NW = 8 * KL;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    kersram_w_if #(.DATA_BITS(DB), .ADDR_CNT_BITS(AB), .BANK_NUM(8)) bus ();

    kersram_w #(.DATA_BITS(DB), .ADDR_CNT_BITS(AB), .KER_ST_LENGTH(KL), .BANK_NUM(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] mem [8][KL];
    int wr_count = 0;
    int viol     = 0;
    int done_cnt = 0;
    logic [AB-1:0] exp_addr_q = '0;
    logic [63:0]   exp_data_q = '0;

    typedef struct {
        logic        start;
        logic        valid;
        logic [63:0] data;
        logic [7:0]  e_cen;
        logic [9:0]  e_addr;
        logic [63:0] e_data;
        logic        e_busy;
        logic        e_done;
        logic        e_ready;
        logic [2:0]  e_bank;
    } vec_t;

    vec_t tbl [7];

    // SRAM model plus strobe-protocol monitor.
    always @(posedge clk) begin
        if (reset === 1'b1) begin
            if (bus.ker_write_done === 1'b1) done_cnt++;
            if (bus.cen_kersw !== 8'hFF) begin
                wr_count++;
                if (bus.cen_kersw !== bus.wen_kersw) viol++;
                if ($countones(~bus.cen_kersw) != 1) viol++;
                if (bus.addr_kersw >= AB'(KL)) viol++;
                else begin
                    for (int b = 0; b < 8; b++) begin
                        if (!bus.cen_kersw[b] && !bus.wen_kersw[b]) mem[b][bus.addr_kersw] = bus.data_kersw;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_load_stats();
        for (int b = 0; b < 8; b++)
            for (int a = 0; a < KL; a++) mem[b][a] = 64'hDEAD_BEEF_DEAD_BEEF;
        wr_count = 0;
        viol     = 0;
        done_cnt = 0;
    endtask

    task automatic do_start();
        bus.start_ker_write = 1'b1;
        bus.din_valid       = 1'b0;
        step();
        bus.start_ker_write = 1'b0;
        check("start_busy", bus.ker_write_busy, 1'b1);
        check("start_ready", bus.din_ready, 1'b1);
    endtask

    // Feed n accepted words; pattern 0 = continuous, 1 = valid 1,0,0,1.
    task automatic feed(input int n, input int pattern, input logic [63:0] base,
                        input bit const_data, input int start_at);
        int idx = 0;
        int cyc = 0;
        int errs = 0;
        logic [2:0]    eb = 3'd0;
        logic [AB-1:0] ew = '0;
        logic rdy;
        logic v;
        logic [63:0] d;
        while (idx < n && cyc < n * 4 + 100) begin
            v = (pattern == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
            d = const_data ? {32'd1, 32'd2} : base + 64'(idx);
            bus.din_valid       = v;
            bus.din_data        = d;
            bus.start_ker_write = (start_at >= 0) && (idx == start_at);
            rdy = bus.din_ready;
            step();
            cyc++;
            if (v && rdy) begin
                if (bus.cen_kersw !== ~(8'd1 << eb)) errs++;
                if (bus.wen_kersw !== ~(8'd1 << eb)) errs++;
                if (bus.addr_kersw !== ew) errs++;
                if (bus.data_kersw !== d) errs++;
                if (idx == 0) begin
                    check("first_cen", bus.cen_kersw, 8'hFE);
                    check("first_addr", bus.addr_kersw, 10'd0);
                end
                if (idx == KL - 1) begin
                    check("bnd_last_cen", bus.cen_kersw, 8'hFE);
                    check("bnd_last_addr", bus.addr_kersw, 10'd287);
                    check("bnd_bank_after", bus.cnt_bank_out, 3'd1);
                end
                if (idx == KL) begin
                    check("bnd_next_cen", bus.cen_kersw, 8'hFD);
                    check("bnd_next_addr", bus.addr_kersw, 10'd0);
                end
                exp_addr_q = ew;
                exp_data_q = d;
                idx++;
                if (ew == AB'(KL - 1)) begin
                    ew = '0;
                    eb = eb + 3'd1;
                end else begin
                    ew = ew + 1'b1;
                end
                if (bus.cnt_bank_out !== eb) errs++;
            end else begin
                if (bus.cen_kersw !== 8'hFF) errs++;
                if (bus.wen_kersw !== 8'hFF) errs++;
                if (bus.addr_kersw !== exp_addr_q) errs++;
                if (bus.data_kersw !== exp_data_q) errs++;
            end
        end
        bus.start_ker_write = 1'b0;
        check("strobe_seq_errs", 64'(errs), 64'd0);
        check("accept_count", 64'(idx), 64'(n));
    endtask

    // Completion checks right after the last accept edge.
    task automatic finish_load();
        check("done_high", bus.ker_write_done, 1'b1);
        check("done_busy_low", bus.ker_write_busy, 1'b0);
        check("done_ready_low", bus.din_ready, 1'b0);
        check("last_cen", bus.cen_kersw, 8'h7F);
        check("last_addr", bus.addr_kersw, 10'(KL - 1));
        bus.din_valid       = 1'b0;
        bus.start_ker_write = 1'b1;
        step();
        bus.start_ker_write = 1'b0;
        check("done_one_cycle", bus.ker_write_done, 1'b0);
        check("start_in_done_ignored", bus.ker_write_busy, 1'b0);
        step();
        check("idle_busy", bus.ker_write_busy, 1'b0);
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("write_count", 64'(wr_count), 64'(NW));
        check("protocol_viol", 64'(viol), 64'd0);
    endtask

    task automatic verify_mem(input string name, input logic [63:0] base, input bit const_data);
        int errs = 0;
        logic [63:0] e;
        for (int b = 0; b < 8; b++) begin
            for (int a = 0; a < KL; a++) begin
                e = const_data ? {32'd1, 32'd2} : base + 64'(b * KL + a);
                if (mem[b][a] !== e) errs++;
            end
        end
        check(name, 64'(errs), 64'd0);
    endtask

    initial begin
        bus.start_ker_write = 1'b0;
        bus.din_valid       = 1'b0;
        bus.din_data        = '0;

        tbl[0] = '{1'b0, 1'b0, 64'h0,  8'hFF, 10'd0, 64'h0,  1'b0, 1'b0, 1'b0, 3'd0};
        tbl[1] = '{1'b1, 1'b0, 64'h0,  8'hFF, 10'd0, 64'h0,  1'b1, 1'b0, 1'b1, 3'd0};
        tbl[2] = '{1'b0, 1'b1, 64'h11, 8'hFE, 10'd0, 64'h11, 1'b1, 1'b0, 1'b1, 3'd0};
        tbl[3] = '{1'b0, 1'b0, 64'h22, 8'hFF, 10'd0, 64'h11, 1'b1, 1'b0, 1'b1, 3'd0};
        tbl[4] = '{1'b1, 1'b1, 64'h33, 8'hFE, 10'd1, 64'h33, 1'b1, 1'b0, 1'b1, 3'd0};
        tbl[5] = '{1'b0, 1'b1, 64'h44, 8'hFE, 10'd2, 64'h44, 1'b1, 1'b0, 1'b1, 3'd0};
        tbl[6] = '{1'b0, 1'b0, 64'h55, 8'hFF, 10'd2, 64'h44, 1'b1, 1'b0, 1'b1, 3'd0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cen", bus.cen_kersw, 8'hFF);
        check("rst_wen", bus.wen_kersw, 8'hFF);
        check("rst_addr", bus.addr_kersw, 10'd0);
        check("rst_data", bus.data_kersw, 64'd0);
        check("rst_busy", bus.ker_write_busy, 1'b0);
        check("rst_done", bus.ker_write_done, 1'b0);
        check("rst_ready", bus.din_ready, 1'b0);
        check("rst_bank", bus.cnt_bank_out, 3'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed cycle vectors from idle
        for (int i = 0; i < 7; i++) begin
            bus.start_ker_write = tbl[i].start;
            bus.din_valid       = tbl[i].valid;
            bus.din_data        = tbl[i].data;
            step();
            check($sformatf("vec%0d_cen", i), bus.cen_kersw, tbl[i].e_cen);
            check($sformatf("vec%0d_wen", i), bus.wen_kersw, tbl[i].e_cen);
            check($sformatf("vec%0d_addr", i), bus.addr_kersw, tbl[i].e_addr);
            check($sformatf("vec%0d_data", i), bus.data_kersw, tbl[i].e_data);
            check($sformatf("vec%0d_busy", i), bus.ker_write_busy, tbl[i].e_busy);
            check($sformatf("vec%0d_done", i), bus.ker_write_done, tbl[i].e_done);
            check($sformatf("vec%0d_ready", i), bus.din_ready, tbl[i].e_ready);
            check($sformatf("vec%0d_bank", i), bus.cnt_bank_out, tbl[i].e_bank);
        end
        bus.start_ker_write = 1'b0;
        bus.din_valid       = 1'b0;

        // Asynchronous reset mid-load returns to idle at once
        done_cnt = 0;
        reset = 1'b0;
        #1;
        check("arst_busy", bus.ker_write_busy, 1'b0);
        check("arst_ready", bus.din_ready, 1'b0);
        check("arst_cen", bus.cen_kersw, 8'hFF);
        exp_addr_q = '0;
        exp_data_q = '0;
        @(negedge clk);
        reset = 1'b1;

        // Full continuous load
        clear_load_stats();
        do_start();
        feed(NW, 0, 64'd0, 1'b0, -1);
        finish_load();
        verify_mem("mem_full", 64'd0, 1'b0);

        // Bubbles 1,0,0,1 with a start re-asserted at word 100
        clear_load_stats();
        do_start();
        feed(NW, 1, 64'd0, 1'b0, 100);
        finish_load();
        verify_mem("mem_bubble", 64'd0, 1'b0);

        // Reset at word 500, then a fresh load from bank 0 address 0
        clear_load_stats();
        do_start();
        feed(500, 0, 64'h5000, 1'b0, -1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_busy", bus.ker_write_busy, 1'b0);
        check("mid_rst_ready", bus.din_ready, 1'b0);
        check("mid_rst_done", bus.ker_write_done, 1'b0);
        check("mid_rst_bank", bus.cnt_bank_out, 3'd0);
        exp_addr_q = '0;
        exp_data_q = '0;
        repeat (2) step();
        check("mid_rst_no_done", 64'(done_cnt), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        clear_load_stats();
        do_start();
        feed(NW, 0, 64'h1_0000_0000, 1'b0, -1);
        finish_load();
        verify_mem("mem_after_rst", 64'h1_0000_0000, 1'b0);

`ifdef KERSW_CKSUM_EN
        // Checksum over a constant-data load, then cleared by the next start
        clear_load_stats();
        do_start();
        check("cksum_cleared", bus.ker_wr_cksum, 32'd0);
        feed(NW, 0, 64'd0, 1'b1, -1);
        finish_load();
        verify_mem("mem_const", 64'd0, 1'b1);
        check("cksum_full", bus.ker_wr_cksum, 32'd6912);
        do_start();
        check("cksum_restart", bus.ker_wr_cksum, 32'd0);
        feed(10, 0, 64'd0, 1'b1, -1);
        check("cksum_partial", bus.ker_wr_cksum, 32'd30);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
